add_chain_seq: RTL



---
 rtl/add_pkg.sv | 13 +
 rtl/add_chain_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared state type and default widths for the adder chain sequencer
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int N_DEF    = 8;
  localparam int IDXW_DEF = 4;

endpackage

// File: rtl/add_chain_seq.sv
// rtl/add_chain_seq.sv - multi-word carry-chaining sequencer around an external ripple adder
// Optional macro ADD_CHAIN_OVF_EN adds the signed-overflow output out_ovf.
module add_chain_seq
  import add_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_x,
  input  logic [N-1:0]    in_y,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            cin_init,
  output logic            add_cin,
  output logic [N-1:0]    add_x,
  output logic [N-1:0]    add_y,
  input  logic [N-1:0]    add_s,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_sum,
  output logic            out_carry,
  output logic            out_last,
`ifdef ADD_CHAIN_OVF_EN
  output logic            out_ovf,
`endif
  output logic [IDXW-1:0] out_idx
);

  state_t          state;
  state_t          state_nx;
  logic            chain_carry;
  logic            cur_last;
  logic [IDXW-1:0] idx;
  logic            accept;

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ADD;
      end
      ADD: begin
        state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Adder operands only move on an accepted beat, so they stay stable through ADD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_x    <= '0;
      add_y    <= '0;
      add_cin  <= 1'b0;
      cur_last <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      add_x    <= in_x;
      add_y    <= in_y;
      add_cin  <= in_first ? cin_init : chain_carry;
      cur_last <= in_last;
      idx      <= in_first ? '0 : idx + 1'b1;
    end
  end

  // The chain carry is dropped once the most-significant word has been added.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_sum     <= '0;
      out_carry   <= 1'b0;
      out_last    <= 1'b0;
      out_idx     <= '0;
      chain_carry <= 1'b0;
    end else if (state == ADD) begin
      out_sum     <= add_s;
      out_carry   <= add_cout;
      out_last    <= cur_last;
      out_idx     <= idx;
      chain_carry <= cur_last ? 1'b0 : add_cout;
    end
  end

`ifdef ADD_CHAIN_OVF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_ovf <= 1'b0;
    end else if (state == ADD) begin
      out_ovf <= cur_last && (add_x[N-1] == add_y[N-1]) && (add_s[N-1] != add_x[N-1]);
    end
  end
`endif

endmodule
